seq_add_sub: RTL and testbench

Multi-cycle, parametrised adder/subtractor. It processes an N-bit operand pair CHUNK bits per clock, using a CHUNK-wide ripple-carry slice whose carry is registered between cycles. It trades latency for area and adds four things a plain ripple adder lacks:
- subtract mode
- external carry/borrow-in
- signed-overflow and zero flags
- valid/ready handshakes on input and output

It sits between the register file/ALU operand muxes and any consumer that can tolerate multi-cycle results.

---
 rtl/seq_add_sub_pkg.sv | 20 ++
 rtl/seq_add_sub_ripple.sv | 44 ++++
 rtl/seq_add_sub.sv | 139 +++++++++++++
 tb/tb_seq_add_sub.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/seq_add_sub_pkg.sv
// Shared definitions for the multi-cycle adder/subtractor: FSM encoding and
// the width helper used to size the chunk counter.
package seq_add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_add_sub_ripple.sv
// Combinational W-bit ripple-carry slice built from single-bit full adders;
// also exposes the carry into the MSB for signed-overflow detection.
module one_bit_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module ripple_chunk_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  logic [W:0] carry_s;

  assign carry_s[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    one_bit_full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry_s[i]),
      .s  (sum[i]),
      .co (carry_s[i+1])
    );
  end

  assign cout  = carry_s[W];
  assign c_msb = carry_s[W-1];

endmodule

// File: rtl/seq_add_sub.sv
// Multi-cycle N-bit adder/subtractor: one CHUNK-wide ripple slice per clock,
// registered inter-chunk carry, valid/ready handshakes and C/V/Z flags.
module seq_add_sub
  import seq_add_sub_pkg::*;
#(
  parameter int N     = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         sub,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Z,
  output logic         Cout,
  output logic         ovf,
  output logic         zero
);

  localparam int K  = N / CHUNK;
  localparam int CW = (clog2(K) < 1) ? 1 : clog2(K);
  localparam logic [CW-1:0] LAST_CNT = CW'(K - 1);

  if ((CHUNK < 1) || (CHUNK > N) || ((N % CHUNK) != 0)) begin : g_param_chk
    $error("seq_add_sub: N must be a positive multiple of CHUNK");
  end

  state_e                   state_q, state_d;
  logic [K-1:0][CHUNK-1:0]  a_q, a_d, b_q, b_d, z_q, z_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     carry_q, carry_d;
  logic                     cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic                     in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic [CHUNK-1:0]         sum_s;
  logic                     cout_s, c_msb_s;

  ripple_chunk_adder #(.W(CHUNK)) u_slice (
    .a     (a_q[cnt_q]),
    .b     (b_q[cnt_q]),
    .cin   (carry_q),
    .sum   (sum_s),
    .cout  (cout_s),
    .c_msb (c_msb_s)
  );

  // Next-state logic: operand capture, per-chunk result write and flag update.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    z_d      = z_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is folded into addition: A + ~B + ~borrow.
          a_d     = A;
          b_d     = sub ? ~B : B;
          carry_d = sub ? ~cin : cin;
          cnt_d   = {CW{1'b0}};
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        z_d[cnt_q] = sum_s;
        carry_d    = cout_s;
        if (cnt_q == LAST_CNT) begin
          cout_d  = cout_s;
          ovf_d   = c_msb_s ^ cout_s;
          zero_d  = (z_d == {N{1'b0}});
          cnt_d   = {CW{1'b0}};
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= IDLE;
      a_q         <= {N{1'b0}};
      b_q         <= {N{1'b0}};
      z_q         <= {N{1'b0}};
      cnt_q       <= {CW{1'b0}};
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      z_q         <= z_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Z         = z_q;
  assign Cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_seq_add_sub.sv
// Self-checking bench: four configurations driven in lockstep, checked against
// an arithmetic reference model, plus directed reset/backpressure scenarios.
module tb_seq_add_sub;

  logic        clk;
  logic        rstb;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] a_in, b_in;
  logic        sub_in, cin_in;

  logic [3:0]  iry, ovl, cov, ovv, zer;
  logic [31:0] z0, z1, z2;
  logic [15:0] z3;

  int checks   = 0;
  int failures = 0;

  int ns_tab [4] = '{32, 32, 32, 16};
  int ks_tab [4] = '{4, 1, 32, 4};

  logic [31:0] r_z;
  logic        r_c, r_o, r_zr;

  seq_add_sub #(.N(32), .CHUNK(8)) d0 (
    .clk(clk), .rstb(rstb), .in_valid(in_valid), .in_ready(iry[0]),
    .A(a_in), .B(b_in), .sub(sub_in), .cin(cin_in),
    .out_valid(ovl[0]), .out_ready(out_ready),
    .Z(z0), .Cout(cov[0]), .ovf(ovv[0]), .zero(zer[0]));

  seq_add_sub #(.N(32), .CHUNK(32)) d1 (
    .clk(clk), .rstb(rstb), .in_valid(in_valid), .in_ready(iry[1]),
    .A(a_in), .B(b_in), .sub(sub_in), .cin(cin_in),
    .out_valid(ovl[1]), .out_ready(out_ready),
    .Z(z1), .Cout(cov[1]), .ovf(ovv[1]), .zero(zer[1]));

  seq_add_sub #(.N(32), .CHUNK(1)) d2 (
    .clk(clk), .rstb(rstb), .in_valid(in_valid), .in_ready(iry[2]),
    .A(a_in), .B(b_in), .sub(sub_in), .cin(cin_in),
    .out_valid(ovl[2]), .out_ready(out_ready),
    .Z(z2), .Cout(cov[2]), .ovf(ovv[2]), .zero(zer[2]));

  seq_add_sub #(.N(16), .CHUNK(4)) d3 (
    .clk(clk), .rstb(rstb), .in_valid(in_valid), .in_ready(iry[3]),
    .A(a_in[15:0]), .B(b_in[15:0]), .sub(sub_in), .cin(cin_in),
    .out_valid(ovl[3]), .out_ready(out_ready),
    .Z(z3), .Cout(cov[3]), .ovf(ovv[3]), .zero(zer[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] zsel(input int i);
    case (i)
      0:       return z0;
      1:       return z1;
      2:       return z2;
      default: return {16'h0000, z3};
    endcase
  endfunction

  // Reference: exact integer arithmetic, then wrap / range-check.
  function automatic void model(input int n, input logic [31:0] a, input logic [31:0] b,
                                input logic s, input logic c,
                                output logic [31:0] z, output logic co,
                                output logic ov, output logic zr);
    longint two_n, half, ua, ub, sa, sb, r, rs, cc;
    two_n = longint'(1) << n;
    half  = two_n >> 1;
    ua    = longint'(a) & (two_n - 1);
    ub    = longint'(b) & (two_n - 1);
    cc    = c ? 64'sd1 : 64'sd0;
    sa    = (ua >= half) ? ua - two_n : ua;
    sb    = (ub >= half) ? ub - two_n : ub;
    r     = s ? (ua - ub - cc) : (ua + ub + cc);
    rs    = s ? (sa - sb - cc) : (sa + sb + cc);
    co    = s ? (r >= 0) : (r >= two_n);
    z     = 32'(r & (two_n - 1));
    ov    = (rs < -half) || (rs >= half);
    zr    = (z == 32'd0);
  endfunction

  // Called just after a falling edge with all DUTs idle.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic c, input int hold);
    int lat [4];
    int cyc;
    logic [31:0] ez;
    logic eco, eov, ezr;
    a_in = a; b_in = b; sub_in = s; cin_in = c; in_valid = 1'b1;
    chk("in_ready_before_accept", 32'(iry), 32'hF);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a_in = $urandom; b_in = $urandom; sub_in = ~s; cin_in = ~c;
    chk("in_ready_busy", 32'(iry), 32'h0);
    lat = '{0, 0, 0, 0};
    cyc = 0;
    while (((lat[0] == 0) || (lat[1] == 0) || (lat[2] == 0) || (lat[3] == 0)) && (cyc < 64)) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (ovl[i] && (lat[i] == 0)) lat[i] = cyc;
      end
    end
    for (int i = 0; i < 4; i++) begin
      model(ns_tab[i], a, b, s, c, ez, eco, eov, ezr);
      chk($sformatf("latency_d%0d", i), 32'(lat[i]), 32'(ks_tab[i]));
      chk($sformatf("z_d%0d", i), zsel(i), ez);
      chk($sformatf("cout_d%0d", i), 32'(cov[i]), 32'(eco));
      chk($sformatf("ovf_d%0d", i), 32'(ovv[i]), 32'(eov));
      chk($sformatf("zero_d%0d", i), 32'(zer[i]), 32'(ezr));
    end
    model(32, a, b, s, c, ez, eco, eov, ezr);
    r_z = z0; r_c = cov[0]; r_o = ovv[0]; r_zr = zer[0];
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      a_in = ~a;
      @(posedge clk);
      @(negedge clk);
      chk("hold_z", z0, ez);
      chk("hold_flags", {29'd0, cov[0], ovv[0], zer[0]}, {29'd0, eco, eov, ezr});
      chk("hold_handshake", {30'd0, iry[0], ovl[0]}, 32'h1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("retire_in_ready", 32'(iry), 32'hF);
    chk("retire_out_valid", 32'(ovl), 32'h0);
  endtask

  initial begin
    rstb = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    a_in = 32'h0000_00FF; b_in = 32'h0000_0001; sub_in = 1'b0; cin_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(iry), 32'hF);
    chk("rst_out_valid", 32'(ovl), 32'h0);
    chk("rst_z", z0 | z1 | z2 | {16'h0000, z3}, 32'h0);
    chk("rst_flags", 32'(cov | ovv | zer), 32'h0);

    rstb = 1'b1;
    do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0);
    chk("carry_chain_z", r_z, 32'h0000_0100);
    chk("carry_chain_flags", {29'd0, r_c, r_o, r_zr}, 32'h0);

    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
    chk("wrap_z", r_z, 32'h0);
    chk("wrap_flags", {29'd0, r_c, r_o, r_zr}, {29'd0, 1'b1, 1'b0, 1'b1});

    do_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 0);
    chk("sub_ovf_z", r_z, 32'h7FFF_FFFF);
    chk("sub_ovf_flags", {29'd0, r_c, r_o, r_zr}, {29'd0, 1'b1, 1'b1, 1'b0});

    do_op(32'd5, 32'd7, 1'b1, 1'b0, 10);
    chk("sub_borrow_z", r_z, 32'hFFFF_FFFE);
    chk("sub_borrow_flags", {29'd0, r_c, r_o, r_zr}, 32'h0);

    // Abort during the third busy cycle of the 32/8 instance.
    a_in = 32'h0101_0101; b_in = 32'h0101_0101; sub_in = 1'b0; cin_in = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rstb = 1'b0;
    #1;
    chk("midop_rst_z", z0, 32'h0);
    chk("midop_rst_handshake", {30'd0, iry[0], ovl[0]}, 32'h2);
    chk("midop_rst_flags", {29'd0, cov[0], ovv[0], zer[0]}, 32'h0);
    @(negedge clk);
    rstb = 1'b1;
    do_op(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b1, 0);
    chk("after_rst_z", r_z, 32'h2222_2222);

    for (int i = 0; i < 200; i++) begin
      do_op($urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)),
            (i % 50 == 7) ? 3 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
